// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter_if
//  Purpose  : Bundles the two requester ports, the shared read-data/error
//             returns and the single memory port of the two-way memory
//             arbiter.
//  Modports : slave  - the arbiter's view (requests and memory replies in,
//                      grants and memory strobes out)
//             master - the environment's view (requesters plus memory)
//  Revision : 1.0  initial release
// ============================================================================
interface mem_arbiter_if;

   // requester 0 (core data port)
   logic        m0_req;
   logic        m0_we;
   logic [31:0] m0_addr;
   logic [31:0] m0_wdata;
   logic        m0_gnt;
   logic        m0_rvalid;

   // requester 1 (program loader)
   logic        m1_req;
   logic        m1_we;
   logic [31:0] m1_addr;
   logic [31:0] m1_wdata;
   logic        m1_gnt;
   logic        m1_rvalid;

   // shared returns
   logic [31:0] rdata;
   logic        err;

   // memory port
   logic        mem_en;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ready;

   modport slave (
      input  m0_req, m0_we, m0_addr, m0_wdata,
      input  m1_req, m1_we, m1_addr, m1_wdata,
      output m0_gnt, m0_rvalid, m1_gnt, m1_rvalid,
      output rdata, err,
      output mem_en, mem_we, mem_addr, mem_wdata,
      input  mem_rdata, mem_ready
   );

   modport master (
      output m0_req, m0_we, m0_addr, m0_wdata,
      output m1_req, m1_we, m1_addr, m1_wdata,
      input  m0_gnt, m0_rvalid, m1_gnt, m1_rvalid,
      input  rdata, err,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      output mem_rdata, mem_ready
   );

endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter
//  Purpose  : Round-robin arbiter giving two requesters access to a single
//             memory port. One access at a time: IDLE -> BUSY (memory strobe
//             held until mem_ready or timeout) -> DONE (one-cycle grant).
//  Ports    : clk  - system clock, rising edge
//             rst  - synchronous active-high reset
//             bus  - mem_arbiter_if.slave: m0/m1 req/we/addr/wdata in,
//                    m0/m1 gnt/rvalid out, shared rdata/err out,
//                    memory en/we/addr/wdata out, rdata/ready in
//  Params   : TIMEOUT - BUSY cycles allowed before the access is aborted
//                       (2..255)
//  Revision : 1.0  initial release
// ============================================================================
module mem_arbiter #(
   parameter int TIMEOUT = 16
) (
   input  logic               clk,
   input  logic               rst,
   mem_arbiter_if.slave       bus
);

   localparam logic [7:0] TIMEOUT_M1 = 8'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t      state_q,      state_d;
   logic        owner_q,      owner_d;       // 0 = m0, 1 = m1
   logic        last_owner_q, last_owner_d;
   logic        we_q,         we_d;
   logic [31:0] addr_q,       addr_d;
   logic [31:0] wdata_q,      wdata_d;
   logic [7:0]  cnt_q,        cnt_d;
   logic [31:0] rdata_q,      rdata_d;
   logic        rd_ok_q,      rd_ok_d;       // access ended as a successful read
   logic        timed_out_q,  timed_out_d;   // access ended by timeout
   logic        win;

   // ------------------------------------------------------------------------
   // Next-state and datapath
   // ------------------------------------------------------------------------
   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      we_d         = we_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      cnt_d        = cnt_q;
      rdata_d      = rdata_q;
      rd_ok_d      = rd_ok_q;
      timed_out_d  = timed_out_q;
      win          = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (bus.m0_req || bus.m1_req) begin
               // On contention the requester that did not own the last
               // access wins; otherwise whoever is asking wins.
               if (bus.m0_req && bus.m1_req) begin
                  win = ~last_owner_q;
               end else begin
                  win = bus.m1_req;
               end
               owner_d = win;
               we_d    = win ? bus.m1_we    : bus.m0_we;
               addr_d  = win ? bus.m1_addr  : bus.m0_addr;
               wdata_d = win ? bus.m1_wdata : bus.m0_wdata;
               cnt_d   = 8'd0;
               state_d = ST_BUSY;
            end
         end

         ST_BUSY: begin
            // mem_ready takes priority so a reply in the final allowed
            // cycle still counts as a success.
            if (bus.mem_ready) begin
               state_d      = ST_DONE;
               last_owner_d = owner_q;
               rd_ok_d      = ~we_q;
               timed_out_d  = 1'b0;
               if (!we_q) begin
                  rdata_d = bus.mem_rdata;
               end
            end else if (cnt_q == TIMEOUT_M1) begin
               state_d      = ST_DONE;
               last_owner_d = owner_q;
               rd_ok_d      = 1'b0;
               timed_out_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         owner_q      <= 1'b0;
         last_owner_q <= 1'b1;      // m0 wins the first contention
         we_q         <= 1'b0;
         addr_q       <= 32'd0;
         wdata_q      <= 32'd0;
         cnt_q        <= 8'd0;
         rdata_q      <= 32'd0;
         rd_ok_q      <= 1'b0;
         timed_out_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         cnt_q        <= cnt_d;
         rdata_q      <= rdata_d;
         rd_ok_q      <= rd_ok_d;
         timed_out_q  <= timed_out_d;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs: decoded from the state so that every pulse vanishes the cycle
   // after a reset, and the memory side is forced to zero outside BUSY.
   // ------------------------------------------------------------------------
   logic is_busy;
   logic is_done;

   assign is_busy = (state_q == ST_BUSY);
   assign is_done = (state_q == ST_DONE);

   assign bus.mem_en    = is_busy;
   assign bus.mem_we    = is_busy & we_q;
   assign bus.mem_addr  = is_busy ? addr_q  : 32'd0;
   assign bus.mem_wdata = is_busy ? wdata_q : 32'd0;

   assign bus.m0_gnt    = is_done & ~owner_q;
   assign bus.m1_gnt    = is_done &  owner_q;
   assign bus.m0_rvalid = is_done & ~owner_q & rd_ok_q;
   assign bus.m1_rvalid = is_done &  owner_q & rd_ok_q;
   assign bus.err       = is_done & timed_out_q;
   assign bus.rdata     = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_arbiter
//  Purpose  : Self-checking bench for mem_arbiter. A transaction-level model
//             tracks pending requests, the round-robin owner and the last
//             read data; each access is predicted from its random memory
//             delay (BUSY length, grant, rvalid, err, rdata).
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;

   localparam int TIMEOUT = 16;
   localparam int NEVER   = 1000;   // memory delay meaning "never ready"

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   mem_arbiter_if bus ();

   mem_arbiter #(.TIMEOUT(TIMEOUT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   // transaction-level model state
   logic        pend   [2];
   logic        pwe    [2];
   logic [31:0] paddr  [2];
   logic [31:0] pwdata [2];
   logic        last_owner_m;
   logic [31:0] rdata_m;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic drive_reqs();
      bus.m0_req   = pend[0];
      bus.m0_we    = pwe[0];
      bus.m0_addr  = paddr[0];
      bus.m0_wdata = pwdata[0];
      bus.m1_req   = pend[1];
      bus.m1_we    = pwe[1];
      bus.m1_addr  = paddr[1];
      bus.m1_wdata = pwdata[1];
   endtask

   task automatic new_req(input int idx, input logic we, input logic [31:0] a, input logic [31:0] wd);
      pend[idx]   = 1'b1;
      pwe[idx]    = we;
      paddr[idx]  = a;
      pwdata[idx] = wd;
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_strobes"},
            {28'd0, bus.mem_en, bus.mem_we, bus.m0_gnt, bus.m1_gnt}, 32'd0);
      check({tag, "_flags"}, {29'd0, bus.m0_rvalid, bus.m1_rvalid, bus.err}, 32'd0);
      check({tag, "_maddr"},  bus.mem_addr,  32'd0);
      check({tag, "_mwdata"}, bus.mem_wdata, 32'd0);
   endtask

   // Starts at the falling edge of an IDLE cycle, ends at the falling edge
   // of the IDLE cycle after DONE. d = BUSY cycle index in which the memory
   // answers; d >= TIMEOUT means it never answers.
   task automatic run_txn(input int d);
      int          w;
      int          busy_len;
      bit          ok;
      logic [31:0] rd;
      drive_reqs();
      if (pend[0] && pend[1]) w = last_owner_m ? 0 : 1;
      else                    w = pend[0] ? 0 : 1;
      ok       = (d < TIMEOUT);
      busy_len = ok ? d + 1 : TIMEOUT;
      rd       = $urandom;
      @(posedge clk);
      for (int k = 0; k < busy_len; k++) begin
         @(negedge clk);
         check("mem_en",    {31'd0, bus.mem_en}, 32'd1);
         check("mem_we",    {31'd0, bus.mem_we}, {31'd0, pwe[w]});
         check("mem_addr",  bus.mem_addr,  paddr[w]);
         check("mem_wdata", bus.mem_wdata, pwdata[w]);
         check("busy_gnt",  {29'd0, bus.m0_gnt, bus.m1_gnt, bus.err}, 32'd0);
         bus.mem_ready = ok && (k == d);
         bus.mem_rdata = (ok && k == d) ? rd : 32'($urandom);
         @(posedge clk);
      end
      @(negedge clk);                                  // DONE cycle
      bus.mem_ready = 1'b0;
      bus.mem_rdata = $urandom;
      last_owner_m  = w[0];
      if (ok && !pwe[w]) rdata_m = rd;
      check("m0_gnt",    {31'd0, bus.m0_gnt},    {31'd0, w == 0});
      check("m1_gnt",    {31'd0, bus.m1_gnt},    {31'd0, w == 1});
      check("m0_rvalid", {31'd0, bus.m0_rvalid}, {31'd0, (w == 0) && ok && !pwe[w]});
      check("m1_rvalid", {31'd0, bus.m1_rvalid}, {31'd0, (w == 1) && ok && !pwe[w]});
      check("err",       {31'd0, bus.err},       {31'd0, !ok});
      check("rdata",     bus.rdata, rdata_m);
      check("done_mem",  {29'd0, bus.mem_en, bus.mem_we, 1'b0}, 32'd0);
      pend[w] = 1'b0;                                  // winner saw its grant
      drive_reqs();
      @(posedge clk);
      @(negedge clk);                                  // IDLE cycle
      check_quiet("idle");
   endtask

   task automatic do_reset();
      rst = 1'b1;
      pend[0] = 1'b0;
      pend[1] = 1'b0;
      drive_reqs();
      bus.mem_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_quiet("reset");
      check("reset_rdata", bus.rdata, 32'd0);
      rst          = 1'b0;
      last_owner_m = 1'b1;
      rdata_m      = 32'd0;
      @(posedge clk);
      @(negedge clk);
      check_quiet("post_reset");
   endtask

   initial begin
      int r;
      int d;
      for (int i = 0; i < 2; i++) begin
         pend[i] = 1'b0; pwe[i] = 1'b0; paddr[i] = 32'd0; pwdata[i] = 32'd0;
      end
      bus.mem_ready = 1'b0;
      bus.mem_rdata = 32'd0;
      last_owner_m  = 1'b1;
      rdata_m       = 32'd0;
      drive_reqs();
      @(negedge clk);
      do_reset();

      // single m0 read answered in the first BUSY cycle
      new_req(0, 1'b0, 32'h100, 32'd0);
      run_txn(0);
      check("first_rdata_hold", bus.rdata, rdata_m);

      // m1 write answered after three wait cycles
      new_req(1, 1'b1, 32'h20, 32'h55AA55AA);
      run_txn(3);

      // m0 read that times out, followed by a normal access
      new_req(0, 1'b0, 32'h300, 32'd0);
      run_txn(NEVER);
      new_req(0, 1'b0, 32'h304, 32'd0);
      run_txn(1);

      // reply in the last allowed cycle is a success
      new_req(1, 1'b0, 32'h400, 32'd0);
      run_txn(TIMEOUT - 1);

      // repeated contention with immediate replies: grants alternate
      for (int i = 0; i < 4; i++) begin
         if (!pend[0]) new_req(0, 1'b0, 32'h1000 + 32'(i), 32'd0);
         if (!pend[1]) new_req(1, 1'b1, 32'h2000 + 32'(i), 32'($urandom));
         run_txn(0);
      end
      pend[0] = 1'b0;
      pend[1] = 1'b0;
      drive_reqs();

      // reset in the second BUSY cycle of an m1 access
      new_req(1, 1'b0, 32'h40, 32'd0);
      drive_reqs();
      @(posedge clk);
      @(negedge clk);
      check("abort_busy1", {31'd0, bus.mem_en}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      check("abort_busy2", {31'd0, bus.mem_en}, 32'd1);
      rst = 1'b1;
      pend[1] = 1'b0;
      drive_reqs();
      @(posedge clk);
      @(negedge clk);
      check_quiet("abort");
      rst          = 1'b0;
      last_owner_m = 1'b1;
      rdata_m      = 32'd0;
      @(posedge clk);
      @(negedge clk);
      check_quiet("abort_after");
      new_req(0, 1'b0, 32'h500, 32'd0);
      new_req(1, 1'b0, 32'h600, 32'd0);
      run_txn(0);                         // model expects m0 to win

      // randomized traffic
      for (int t = 0; t < 150; t++) begin
         for (int i = 0; i < 2; i++) begin
            if (!pend[i] && ($urandom_range(0, 1) == 1))
               new_req(i, 1'($urandom_range(0, 1)), 32'($urandom), 32'($urandom));
         end
         if (!pend[0] && !pend[1])
            new_req($urandom_range(0, 1), 1'($urandom_range(0, 1)),
                    32'($urandom), 32'($urandom));
         r = $urandom_range(0, 9);
         if (r < 6)       d = $urandom_range(0, 3);
         else if (r < 8)  d = $urandom_range(4, TIMEOUT - 1);
         else if (r == 8) d = TIMEOUT - 1;
         else             d = NEVER;
         run_txn(d);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Parameters
REQ-001 TIMEOUT, default 16, meaning: maximum number of cycles spent in BUSY waiting for mem_ready before the access is aborted; legal range 2..255.

Interface
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 m0_req / m1_req  input  1  access request from requester 0 (core data port) / requester 1 (program loader).
REQ-005 m0_we / m1_we  input  1  1 = write, 0 = read.
REQ-006 m0_addr / m1_addr  input  32  byte address.
REQ-007 m0_wdata / m1_wdata  input  32  write data.
REQ-008 m0_gnt / m1_gnt  output  1  one-cycle pulse marking completion (or abort) of that requester's access.
REQ-009 m0_rvalid / m1_rvalid  output  1  one-cycle pulse, coincident with gnt, on successful read completion.
REQ-010 rdata  output  32  read data, shared by both requesters; valid while either rvalid is high.
REQ-011 err  output  1  one-cycle pulse, coincident with gnt, when the access timed out.
REQ-012 mem_en  output  1  memory access strobe.
REQ-013 mem_we  output  1  memory write enable.
REQ-014 mem_addr  output  32  memory address.
REQ-015 mem_wdata  output  32  memory write data.
REQ-016 mem_rdata  input  32  memory read data; sampled when mem_ready is high.
REQ-017 mem_ready  input  1  memory completion; may assert in any BUSY cycle, including the first.

Function
REQ-018 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-019 IDLE: if any req is high at the clock edge, the arbiter SHALL latch the owner, we, addr and wdata, clear the timeout counter, and enter BUSY; otherwise it SHALL stay in IDLE.
REQ-020 Arbitration: a single requester SHALL win. If both request, the winner SHALL be the requester that is not last_owner (round robin).
REQ-021 mem_en SHALL be 1 only in BUSY. While mem_en is 1, mem_we, mem_addr and mem_wdata SHALL equal the latched values; in other states they SHALL be 0.
REQ-022 BUSY with mem_ready=1 at the edge: the arbiter SHALL enter DONE, set last_owner to the owner, and for a read register mem_rdata into rdata.
REQ-023 BUSY with mem_ready=0 and counter = TIMEOUT-1: the arbiter SHALL enter DONE with err flagged and SHALL leave rdata unchanged.
REQ-024 BUSY with mem_ready=0 otherwise: the counter SHALL increment and the FSM SHALL stay in BUSY.
REQ-025 If mem_ready arrives in the same cycle the timeout would fire, it SHALL count as success, not as an error.
REQ-026 DONE SHALL last exactly one cycle, then return to IDLE. During DONE, owner's gnt=1; owner's rvalid=1 if the access was a successful read; err=1 if the access timed out. A timed-out access still sets last_owner.
REQ-027 Requests SHALL be ignored while in BUSY or DONE.
REQ-028 Requesters SHALL hold req, we, addr and wdata stable until they see gnt. A req still high in the cycle after gnt is treated as a new request.
REQ-029 Latency: a req sampled in IDLE at edge N SHALL give mem_en=1 in cycle N+1. A mem_ready sampled at edge M SHALL give gnt in cycle M+1. The earliest next mem_en SHALL be in cycle M+3.
REQ-030 The non-owner's gnt, rvalid and the memory-side outputs SHALL be 0 in DONE.

Reset
REQ-031 When rst=1 at an edge, the arbiter SHALL enter IDLE and clear all outputs, rdata, counter and latches to 0, and set last_owner to 1 so that m0 wins the first contention.
REQ-032 A reset in BUSY or DONE SHALL abort the access with no gnt, rvalid or err pulse; mem_en SHALL be 0 from the next cycle.

Verification
REQ-033 Reset, then m0 reads addr 0x100 with mem_ready high on the first BUSY cycle and mem_rdata=0xDEADBEEF -> mem_en high for 1 cycle; m0_gnt=m0_rvalid=1 and rdata=0xDEADBEEF one cycle later; err=0.
REQ-034 m0 and m1 request together repeatedly, memory ready immediately -> grants alternate m0, m1, m0, m1; each mem_en is separated by two idle cycles.
REQ-035 m1 writes 0x55AA55AA to 0x20 with mem_ready delayed 3 cycles -> mem_en held 4 cycles with stable mem_addr/mem_wdata/mem_we=1; m1_gnt=1, m1_rvalid=0.
REQ-036 m0 read, mem_ready never asserted, TIMEOUT=16 -> mem_en high exactly 16 cycles; then m0_gnt=err=1, m0_rvalid=0, rdata unchanged; then the next request is serviced normally.
REQ-037 Reset asserted in the 2nd BUSY cycle of an m1 access -> no gnt/rvalid/err pulse; mem_en=0 next cycle; next contention granted to m0.
REQ-038 mem_ready asserted in the final timeout cycle (cycle 16) -> success: rvalid=1, err=0.
